id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: NOP_INSTR, 32'h0000_0000, instruction word held in the IF/ID register after reset or flush.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 if_instr  input  32  fetched instruction from fetch stage.
REQ-005 if_pcplus4  input  32  PC+4 of the fetched instruction.
REQ-006 if_valid  input  1  fetch output valid this cycle.
REQ-007 stall  input  1  hold IF/ID register contents.
REQ-008 flush  input  1  squash IF/ID register (taken branch).
REQ-009 wb_regwrite  input  1  writeback enable.
REQ-010 wb_rd  input  5  writeback register index.
REQ-011 wb_data  input  32  writeback data.
REQ-012 id_valid  output  1  decoded instruction valid.
REQ-013 id_pcplus4  output  32  registered PC+4.
REQ-014 id_rs, id_rt, id_rd  output  5 each  instr[25:21], [20:16], [15:11].
REQ-015 id_opcode, id_funct  output  6 each  instr[31:26], instr[5:0].
REQ-016 id_rs_data, id_rt_data  output  32 each  register file read data.
REQ-017 id_imm_sext  output  32  sign-extended instr[15:0].
REQ-018 id_branch  output  1  opcode 6'h04 (beq) and id_valid.
REQ-019 id_branch_target  output  32  id_pcplus4 + (id_imm_sext << 2), modulo 2^32.

Function
REQ-020 IF/ID register SHALL update on each rising clk edge by priority: flush, then stall, then load.
REQ-021 flush=1: instr <= NOP_INSTR, valid <= 0, pcplus4 <= 0; flush overrides simultaneous stall.
REQ-022 stall=1, flush=0: instr, pcplus4, valid held unchanged.
REQ-023 Otherwise: instr <= if_instr, pcplus4 <= if_pcplus4, valid <= if_valid; latency one cycle.
REQ-024 All id_* field/immediate/branch outputs SHALL be combinational from the IF/ID register.
REQ-025 Register file: 32 x 32-bit, two combinational read ports (addressed by id_rs, id_rt), one write port.
REQ-026 Write on rising edge when wb_regwrite=1 and wb_rd != 0; writes to register 0 ignored; register 0 always reads 0.
REQ-027 Writes SHALL proceed regardless of stall, flush or id_valid.
REQ-028 Branch target addition SHALL wrap silently at 32 bits.

Reset
REQ-029 reset=0 SHALL asynchronously clear: instr to NOP_INSTR, valid to 0, pcplus4 to 0, all 32 registers to 0.
REQ-030 Consequently, during reset all outputs read 0 (id_branch_target = 0, id_branch = 0).
REQ-031 Reset asserted mid-stall or mid-write SHALL dominate; the pending write is discarded.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN defined: a read whose address equals wb_rd (non-zero) while wb_regwrite=1 returns wb_data in the same cycle.
REQ-033 Macro undefined: that read returns the old register value; new value visible from the next cycle.

Structure
REQ-034 Shared package id_pkg SHALL hold the opcode/funct constants (OP_RTYPE 6'h00, OP_BEQ 6'h04, OP_LW 6'h23, OP_SW 6'h2B) and the 5-bit register index typedef.
REQ-035 Register file SHALL be a separate sub-module regfile32, instantiated once.

Verification
REQ-036 Reset: hold reset=0 two cycles, then release -> id_valid=0, all register reads 0, id_branch=0.
REQ-037 Load: if_instr=32'h1022_0003 (beq $1,$2,3), if_pcplus4=32'h0000_0010, if_valid=1 -> next cycle id_branch=1, id_rs=1, id_rt=2, id_imm_sext=3, id_branch_target=32'h0000_001C.
REQ-038 Stall/flush: stall=1 with new if_instr -> outputs unchanged; stall=1 and flush=1 together -> id_valid=0, instr = NOP_INSTR.
REQ-039 Register write: wb_regwrite=1, wb_rd=5, wb_data=32'hDEAD_BEEF; next cycle id_rs=5 reads 32'hDEAD_BEEF; wb_rd=0 write leaves register 0 reading 0.
REQ-040 Bypass: same-cycle write and read of register 7 with 32'h1234_5678 -> id_rs_data=32'h1234_5678 with REGFILE_BYPASS_EN, old value without.
REQ-041 Negative immediate: instr[15:0]=16'hFFFF, pcplus4=32'h0000_0004 -> id_imm_sext=32'hFFFF_FFFF, id_branch_target=32'h0000_0000.

Source files
------------

// File: rtl/id_pkg.sv
// Shared ID-stage types: opcode/funct constants, register index type,
// IF/ID bundle and immediate sign-extension helper.
package id_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch/writeback inputs and decoded outputs of the ID stage.
// master: drives fetch, stall/flush, writeback; slave: the stage.
interface id_stage_if;
  import id_pkg::*;

  logic [31:0] if_instr;
  logic [31:0] if_pcplus4;
  logic        if_valid;
  logic        stall;
  logic        flush;
  logic        wb_regwrite;
  reg_idx_t    wb_rd;
  logic [31:0] wb_data;

  logic        id_valid;
  logic [31:0] id_pcplus4;
  reg_idx_t    id_rs;
  reg_idx_t    id_rt;
  reg_idx_t    id_rd;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm_sext;
  logic        id_branch;
  logic [31:0] id_branch_target;

  modport master (
    output if_instr, if_pcplus4, if_valid,
    output stall, flush,
    output wb_regwrite, wb_rd, wb_data,
    input  id_valid, id_pcplus4,
    input  id_rs, id_rt, id_rd,
    input  id_opcode, id_funct,
    input  id_rs_data, id_rt_data,
    input  id_imm_sext, id_branch,
    input  id_branch_target
  );

  modport slave (
    input  if_instr, if_pcplus4, if_valid,
    input  stall, flush,
    input  wb_regwrite, wb_rd, wb_data,
    output id_valid, id_pcplus4,
    output id_rs, id_rt, id_rd,
    output id_opcode, id_funct,
    output id_rs_data, id_rt_data,
    output id_imm_sext, id_branch,
    output id_branch_target
  );

endinterface

// File: rtl/regfile32.sv
// 32x32 register file, 2 comb read ports, 1 write port, r0 = 0.
// REGFILE_BYPASS_EN: same-cycle write data forwarded to reads.
module regfile32
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  reg_idx_t    ra1_i,
  input  reg_idx_t    ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  reg_idx_t    wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [32];
  logic        wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wa_i == ra1_i))
      rd1_o = wd_i;
    if (wr_en && (wa_i == ra2_i))
      rd2_o = wd_i;
`else
`endif
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register (flush > stall > load), field
// decode, regfile read, beq detect and branch target. Macro:
// REGFILE_BYPASS_EN enables write-to-read forwarding.
// Ports: clk, reset (async active-low), bus (id_stage_if.slave).
module id_stage
  import id_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  id_stage_if.slave  bus
);

  if_id_t if_id_q;
  if_id_t if_id_d;

  always_comb begin
    if_id_d = if_id_q;
    priority case (1'b1)
      bus.flush: begin
        if_id_d.instr   = NOP_INSTR;
        if_id_d.pcplus4 = '0;
        if_id_d.valid   = 1'b0;
      end
      bus.stall: ;
      default: begin
        if_id_d.instr   = bus.if_instr;
        if_id_d.pcplus4 = bus.if_pcplus4;
        if_id_d.valid   = bus.if_valid;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_q.instr   <= NOP_INSTR;
      if_id_q.pcplus4 <= '0;
      if_id_q.valid   <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  logic [31:0] instr;
  logic [31:0] imm;

  assign instr = if_id_q.instr;
  assign imm   = sext16(instr[15:0]);

  assign bus.id_valid    = if_id_q.valid;
  assign bus.id_pcplus4  = if_id_q.pcplus4;
  assign bus.id_opcode   = instr[31:26];
  assign bus.id_rs       = instr[25:21];
  assign bus.id_rt       = instr[20:16];
  assign bus.id_rd       = instr[15:11];
  assign bus.id_funct    = instr[5:0];
  assign bus.id_imm_sext = imm;

  assign bus.id_branch =
    if_id_q.valid && (instr[31:26] == OP_BEQ);

  // word offset; carry out of bit 31 is dropped
  assign bus.id_branch_target =
    if_id_q.pcplus4 + {imm[29:0], 2'b00};

  regfile32 u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1_i (instr[25:21]),
    .ra2_i (instr[20:16]),
    .rd1_o (bus.id_rs_data),
    .rd2_o (bus.id_rt_data),
    .we_i  (bus.wb_regwrite),
    .wa_i  (bus.wb_rd),
    .wd_i  (bus.wb_data)
  );

endmodule
